// File: rtl/key_sched_ctrl.sv
// Key load sequencer for a key-locked FSM core: receives a serial key plus
// an even-parity bit over a valid/ready handshake and commits it to key_out.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_start          start or restart a key load
//   key_bit, key_valid  serial key stream (MSB first, then parity)
//   key_ready           high while the controller accepts key bits
//   key_out             committed key to the locked core
//   core_rst            reset to the locked core (held until key is released)
//   locked_ok           core running with a committed key
//   lock_fault          sticky fault after MAX_FAIL consecutive bad loads
//   busy                load / check / release in progress
//   fail_cnt            consecutive failure count
module key_sched_ctrl #(
    parameter int KEY_W    = 8,
    parameter int MAX_FAIL = 3,
    parameter int REL_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             core_rst,
    output logic             locked_ok,
    output logic             lock_fault,
    output logic             busy,
    output logic [3:0]       fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_REL,
        S_RUN,
        S_FAULT
    } state_t;

    localparam int CNT_W = $clog2(KEY_W + 1);
    // Bit count at which the next transfer is the parity bit.
    localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(KEY_W);
    localparam logic [3:0]       FAIL_MAX = 4'(MAX_FAIL);
    localparam logic [3:0]       REL_LAST = 4'(REL_CYC - 1);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] sh_q, sh_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       rel_cnt_q, rel_cnt_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             core_rst_q, core_rst_d;
    logic             locked_ok_q, locked_ok_d;
    logic             lock_fault_q, lock_fault_d;
    logic             busy_q, busy_d;
    logic [3:0]       fail_cnt_q, fail_cnt_d;
    logic [3:0]       fail_inc;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        key_out_d  = key_out_q;
        fail_cnt_d = fail_cnt_q;
        fail_inc   = fail_cnt_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                // Restart wins over any bit presented in the same cycle.
                if (load_start) begin
                    bit_cnt_d = '0;
                end else if (key_valid) begin
                    if (bit_cnt_q == PAR_IDX) begin
                        par_d   = key_bit;
                        state_d = S_CHECK;
                    end else begin
                        sh_d      = {sh_q[KEY_W-2:0], key_bit};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (par_q == ^sh_q) begin
                    key_out_d  = sh_q;
                    fail_cnt_d = '0;
                    rel_cnt_d  = '0;
                    state_d    = S_REL;
                end else begin
                    fail_cnt_d = fail_inc;
                    state_d    = (fail_inc == FAIL_MAX) ? S_FAULT : S_IDLE;
                end
            end
            S_REL: begin
                if (rel_cnt_q == REL_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                if (load_start) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up
        // with the state they describe.
        core_rst_d   = (state_d != S_RUN);
        locked_ok_d  = (state_d == S_RUN);
        lock_fault_d = (state_d == S_FAULT);
        busy_d       = (state_d == S_SHIFT) || (state_d == S_CHECK) ||
                       (state_d == S_REL);
        if (state_d == S_FAULT) begin
            key_out_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sh_q         <= '0;
            par_q        <= 1'b0;
            bit_cnt_q    <= '0;
            rel_cnt_q    <= '0;
            key_out_q    <= '0;
            core_rst_q   <= 1'b1;
            locked_ok_q  <= 1'b0;
            lock_fault_q <= 1'b0;
            busy_q       <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            par_q        <= par_d;
            bit_cnt_q    <= bit_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            key_out_q    <= key_out_d;
            core_rst_q   <= core_rst_d;
            locked_ok_q  <= locked_ok_d;
            lock_fault_q <= lock_fault_d;
            busy_q       <= busy_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign key_ready  = (state_q == S_SHIFT);
    assign key_out    = key_out_q;
    assign core_rst   = core_rst_q;
    assign locked_ok  = locked_ok_q;
    assign lock_fault = lock_fault_q;
    assign busy       = busy_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Testbench for key_sched_ctrl: randomized key loads against a load-level
// reference model, with a scoreboard checked whenever a load completes.
module tb_key_sched_ctrl;

    localparam int KEY_W    = 8;
    localparam int MAX_FAIL = 3;
    localparam int REL_CYC  = 2;

    logic             clk;
    logic             rst;
    logic             load_start;
    logic             key_bit;
    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_out;
    logic             core_rst;
    logic             locked_ok;
    logic             lock_fault;
    logic             busy;
    logic [3:0]       fail_cnt;

    key_sched_ctrl #(
        .KEY_W   (KEY_W),
        .MAX_FAIL(MAX_FAIL),
        .REL_CYC (REL_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_out   (key_out),
        .core_rst  (core_rst),
        .locked_ok (locked_ok),
        .lock_fault(lock_fault),
        .busy      (busy),
        .fail_cnt  (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [3:0]       fc;
        logic             flt;
        logic             ok;
        logic             crst;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: committed key, failure streak, fault flag.
    logic [KEY_W-1:0] m_key   = '0;
    int               m_fail  = 0;
    bit               m_fault = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drive one complete key load and push the expected outcome.
    task automatic do_load(input logic [KEY_W-1:0] key, input logic par,
                           input int stall_pos, input int stall_len,
                           input bit rnd, input int restart_after);
        int         st[KEY_W+1];
        int         cyc;
        bit         good;
        exp_t       e;
        logic [KEY_W:0] bits;
        bits = {key, par};
        cyc  = 0;
        if (restart_after > 0) cyc += restart_after + 1;
        for (int i = 0; i <= KEY_W; i++) begin
            st[i] = rnd ? int'($urandom_range(0, 2)) : 0;
            if (i == stall_pos) st[i] += stall_len;
            cyc += st[i] + 1;
        end
        good = ((($countones(key) + int'(par)) % 2) == 0);
        if (good) begin
            m_key  = key;
            m_fail = 0;
        end else begin
            m_fail++;
            if (m_fail == MAX_FAIL) begin
                m_fault = 1'b1;
                m_key   = '0;
            end
        end
        e.key  = m_key;
        e.fc   = 4'(m_fail);
        e.flt  = m_fault;
        e.ok   = good;
        e.crst = !good;
        e.lat  = cyc + 1 + (good ? REL_CYC : 0);
        sb.push_back(e);

        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("start_core_rst", 32'(core_rst), 32'd1);
        chk("start_locked_ok", 32'(locked_ok), 32'd0);
        chk("start_key_ready", 32'(key_ready), 32'd1);
        if (restart_after > 0) begin
            for (int i = 0; i < restart_after; i++) begin
                key_valid = 1'b1;
                key_bit   = 1'($urandom);
                @(posedge clk); #1;
            end
            load_start = 1'b1;
            key_valid  = 1'b1;
            key_bit    = 1'($urandom);
            @(posedge clk); #1;
            load_start = 1'b0;
            chk("restart_ready", 32'(key_ready), 32'd1);
        end
        for (int i = 0; i <= KEY_W; i++) begin
            key_valid = 1'b0;
            repeat (st[i]) begin
                @(posedge clk); #1;
            end
            key_valid = 1'b1;
            key_bit   = bits[KEY_W-i];
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        chk("ready_after_parity", 32'(key_ready), 32'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Monitor: a load completes when busy falls outside reset.
    initial begin : mon
        bit   prev;
        int   bc;
        exp_t e;
        prev = 1'b0;
        bc   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                bc   = 0;
            end else begin
                if (busy) begin
                    bc++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("key_out", 32'(key_out), 32'(e.key));
                        chk("fail_cnt", 32'(fail_cnt), 32'(e.fc));
                        chk("lock_fault", 32'(lock_fault), 32'(e.flt));
                        chk("locked_ok", 32'(locked_ok), 32'(e.ok));
                        chk("core_rst", 32'(core_rst), 32'(e.crst));
                        chk("latency", 32'(bc), 32'(e.lat));
                    end
                    bc = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        logic [KEY_W-1:0] k;
        logic             p;
        int               ra;
        bit               bad;
        rst        = 1'b1;
        load_start = 1'b0;
        key_bit    = 1'b0;
        key_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_key_out", 32'(key_out), 32'd0);
        chk("rst_locked_ok", 32'(locked_ok), 32'd0);
        chk("rst_lock_fault", 32'(lock_fault), 32'd0);
        chk("rst_key_ready", 32'(key_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_load(8'hA5, 1'b0, -1, 0, 1'b0, 0);
        wait_drain();
        do_load(8'h81, 1'b0, 4, 3, 1'b0, 0);
        wait_drain();
        do_load(8'h3C, 1'b0, -1, 0, 1'b0, 5);
        wait_drain();
        do_load(8'h7F, 1'b1, -1, 0, 1'b0, 0);
        wait_drain();
        do_load(8'h01, 1'b0, -1, 0, 1'b0, 0);
        wait_drain();

        for (int n = 0; n < 16; n++) begin
            k  = 8'($urandom);
            p  = ^k;
            if (m_fail < MAX_FAIL - 1 && $urandom_range(0, 3) == 0) p = ~p;
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            do_load(k, p, -1, 0, 1'b1, ra);
            wait_drain();
        end

        do_load(8'h5A, 1'b0, -1, 0, 1'b0, 0);
        wait_drain();
        repeat (MAX_FAIL) begin
            do_load(8'h01, 1'b0, -1, 0, 1'b1, 0);
            wait_drain();
        end

        bad = 1'b0;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i <= KEY_W + 3; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'($urandom);
            @(posedge clk); #1;
            if (busy || key_ready || !lock_fault || !core_rst) bad = 1'b1;
        end
        key_valid = 1'b0;
        chk("fault_hold", 32'(bad), 32'd0);
        chk("fault_key_out", 32'(key_out), 32'd0);
        chk("fault_fail_cnt", 32'(fail_cnt), 32'(MAX_FAIL));

        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_key   = '0;
        m_fail  = 0;
        m_fault = 1'b0;
        @(posedge clk); #1;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_bit   = 1'b1;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        chk("arst_key_out", 32'(key_out), 32'd0);
        chk("arst_key_ready", 32'(key_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_fail_cnt", 32'(fail_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle_busy", 32'(busy), 32'd0);
        chk("arst_idle_key", 32'(key_out), 32'd0);
        do_load(8'hA5, 1'b0, -1, 0, 1'b0, 0);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
- Sequencing controller placed in front of a key-locked FSM benchmark core.
- Accepts a serial key plus an even-parity bit over a valid/ready handshake and validates it.
- Holds the locked core in reset until a key is committed, then drives the parallel keyinput bus and releases the core.
- Counts failed loads; after MAX_FAIL consecutive failures it enters a sticky fault state that only rst clears.

Parameters:
KEY_W, 8, number of key bits delivered to the locked core (keyinput bus width)
MAX_FAIL, 3, consecutive parity failures that trigger sticky FAULT (1..15)
REL_CYC, 2, cycles core_rst stays high after a good key is committed (1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
load_start  input  1  single-cycle request to begin a key load
key_bit  input  1  serial key data, MSB first, followed by one parity bit
key_valid  input  1  key_bit is valid this cycle
key_ready  output  1  controller accepts key_bit this cycle
key_out  output  KEY_W  committed key, driven to the locked core's keyinput bits
core_rst  output  1  active-high reset to the locked core
locked_ok  output  1  core is running with a committed key
lock_fault  output  1  sticky fault: MAX_FAIL consecutive failures
busy  output  1  high in SHIFT, CHECK and RELEASE
fail_cnt  output  4  consecutive failure count, saturating at MAX_FAIL

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - state=IDLE, key_out=0, core_rst=1, locked_ok=0, lock_fault=0, busy=0, key_ready=0, fail_cnt=0.
  - Shift register, bit counter and release counter are all 0.
- States: IDLE, SHIFT, CHECK, RELEASE, RUN, FAULT. Outputs are registered, except key_ready, which is a combinational decode of state (1 only in SHIFT).
- IDLE: core_rst=1. load_start=1 -> SHIFT, and bit counter cleared.
- SHIFT:
  - A transfer occurs on a cycle with key_valid & key_ready. The first KEY_W transfers shift into the shift register MSB-first. Transfer KEY_W+1 is the parity bit.
  - After the parity transfer the next state is CHECK. key_ready is 0 from the following cycle.
  - key_valid=0 stalls the load with no timeout. key_valid while key_ready=0 is ignored.
  - load_start=1 in SHIFT restarts the load: bit counter=0, and any bit presented that cycle is discarded.
- CHECK (exactly 1 cycle): the parity bit is correct when it equals the XOR of the KEY_W key bits (even parity overall).
  - Pass: key_out <= shift register, fail_cnt <= 0, next state RELEASE.
  - Fail: key_out unchanged, fail_cnt <= fail_cnt+1. If the new count equals MAX_FAIL, next state FAULT; otherwise IDLE.
- RELEASE: core_rst=1 for exactly REL_CYC cycles, then RUN.
- RUN: core_rst=0, locked_ok=1. load_start=1 -> SHIFT, with core_rst=1 and locked_ok=0 from the next cycle (the core is re-held during re-keying).
- FAULT: lock_fault=1, core_rst=1, key_out forced to 0. load_start is ignored; only rst exits this state.
- Re-key failure: a failed load entered from RUN returns to IDLE, not RUN. The core stays held and the old key_out is retained.
- Reset mid-operation: rst in any state aborts the load and reloads all reset values; a partial key is never committed.
- Simultaneous events: load_start in the same cycle as the parity transfer is a restart, not a CHECK (restart has priority).
- Latency: a good load with no stalls takes KEY_W+1 SHIFT cycles + 1 CHECK + REL_CYC RELEASE before locked_ok rises. With defaults that is 12 cycles after load_start is sampled.

Test Plan:
- Reset check: rst pulse -> core_rst=1, key_out=0, locked_ok=0, lock_fault=0, key_ready=0.
- Good load: key 0xA5 with parity 0 (popcount 4) streamed with no stalls -> key_out=0xA5 in the cycle after CHECK, core_rst=1 for 2 cycles, then core_rst=0 and locked_ok=1, 12 cycles after load_start.
- Stalled load: key 0x81 parity 0 with key_valid dropped for 3 cycles mid-stream -> same result, latency extended by 3 cycles, no bit lost or duplicated.
- Bad parity: key 0x01 with parity 0 -> fail_cnt=1, return to IDLE, key_out unchanged, core_rst=1.
  - Three consecutive bad loads -> lock_fault=1, key_out=0.
  - A further load_start in FAULT -> no effect.
- Restart and re-key:
  - load_start after 5 bits -> counter restarts; a following full 0x3C/0 load commits 0x3C.
  - From RUN, load_start -> core_rst=1 the next cycle; a new key 0x7F/1 then commits 0x7F.
- Async reset during SHIFT (bit 4) -> immediate IDLE, key_out stays 0, and a subsequent good load behaves as in the good-load scenario.
